// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the variable-distance shift sequencer.
package shift_seq_pkg;

    localparam int SIZE     = 32;
    localparam int CNT_BITS = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter that saturates at zero and flags a count of one.
module shift_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic [W-1:0] count,
    output logic         one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign one = (count == W'(1));

endmodule

// File: rtl/shift_seq.sv
// Sequencer driving a 4-mode shift register through load, k shifts and capture.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int size     = SIZE,
    parameter int cnt_bits = $clog2(size)
) (
    input  logic                clk,
    input  logic                r,
    input  logic                start,
    input  logic                dir,
    input  logic                arith,
    input  logic [cnt_bits-1:0] amount,
    input  logic [size-1:0]     data_in,
    input  logic [size-1:0]     q_in,
    output logic [1:0]          s,
    output logic                si,
    output logic [size-1:0]     pi,
    output logic                busy,
    output logic                done,
    output logic [size-1:0]     result
);

    state_t              state;
    logic                dir_q;
    logic                arith_q;
    logic [cnt_bits-1:0] amt_q;
    logic [cnt_bits-1:0] count;
    logic                cnt_one;

    shift_cnt #(
        .W(cnt_bits)
    ) u_cnt (
        .clk  (clk),
        .rst_n(r),
        .load (state == LOAD),
        .dec  (state == SHIFT),
        .din  (amt_q),
        .count(count),
        .one  (cnt_one)
    );

    // Sign fill only matters for arithmetic right shifts
    assign si = dir_q & arith_q & q_in[size-1];

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state   <= IDLE;
            s       <= S_HOLD;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            pi      <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            amt_q   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        s       <= S_LOAD;
                        busy    <= 1'b1;
                        dir_q   <= dir;
                        arith_q <= arith;
                        amt_q   <= amount;
                        pi      <= data_in;
                    end
                end
                LOAD: begin
                    if (amt_q == '0) begin
                        state <= DONE;
                        s     <= S_HOLD;
                    end else begin
                        state <= SHIFT;
                        s     <= dir_q ? S_RIGHT : S_LEFT;
                    end
                end
                SHIFT: begin
                    if (cnt_one) begin
                        state <= DONE;
                        s     <= S_HOLD;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= q_in;
                end
                default: begin
                    state <= IDLE;
                    s     <= S_HOLD;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Randomized and directed bench for shift_seq against an operation-level model.
module tb_shift_seq;

    logic        clk;
    logic        r;
    logic        start;
    logic        dir;
    logic        arith;
    logic [4:0]  amount;
    logic [31:0] data_in;
    logic [31:0] q_reg;
    logic [1:0]  s;
    logic        si;
    logic [31:0] pi;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        reg_rst;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq dut (
        .clk    (clk),
        .r      (r),
        .start  (start),
        .dir    (dir),
        .arith  (arith),
        .amount (amount),
        .data_in(data_in),
        .q_in   (q_reg),
        .s      (s),
        .si     (si),
        .pi     (pi),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 4-mode shift register the sequencer drives
    assign reg_rst = ~r;
    always_ff @(posedge clk or posedge reg_rst) begin
        if (reg_rst) q_reg <= '0;
        else begin
            case (s)
                2'b01:   q_reg <= {q_reg[30:0], si};
                2'b10:   q_reg <= {si, q_reg[31:1]};
                2'b11:   q_reg <= pi;
                default: q_reg <= q_reg;
            endcase
        end
    end

    // Operation-level model: phase p counts cycles since acceptance
    bit          m_active;
    int          m_p;
    int          m_k;
    bit          m_dir;
    bit          m_arith;
    bit          m_done;
    logic [31:0] m_op;
    logic [31:0] m_exp;
    logic [31:0] m_result;

    function automatic logic [31:0] shifted(
        input logic [31:0] d, input bit dr, input bit ar, input int k);
        if (!dr) return d << k;
        if (ar) return 32'($signed(d) >>> k);
        return d >> k;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_p = 0;
        m_k = 0;
        m_dir = 0;
        m_arith = 0;
        m_done = 0;
        m_op = '0;
        m_exp = '0;
        m_result = '0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (m_active) begin
            if (m_p == m_k + 1) begin
                m_done = 1;
                m_result = m_exp;
                m_active = 0;
            end else begin
                m_p++;
            end
        end else if (start) begin
            m_active = 1;
            m_p = 0;
            m_k = int'(amount);
            m_dir = dir;
            m_arith = arith;
            m_op = data_in;
            m_exp = shifted(data_in, dir, arith, int'(amount));
        end
    endtask

    function automatic logic [1:0] exp_s();
        if (!m_active) return 2'b00;
        if (m_p == 0) return 2'b11;
        if (m_p <= m_k) return m_dir ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("s", 32'(s), 32'(exp_s()));
        chk("pi", pi, m_op);
        chk("result", result, m_result);
        chk("si", 32'(si), 32'(m_dir & m_arith & q_reg[31]));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!r) model_reset();
        else model_edge();
        @(negedge clk);
        compare();
    endtask

    // Called in the cycle after the accepting edge; returns in the done cycle
    task automatic wait_done(output int lat, output int bc, output int sc);
        lat = 0;
        bc = 0;
        sc = 0;
        forever begin
            if (busy) bc++;
            if (s == 2'b01 || s == 2'b10) sc++;
            if (done) break;
            if (lat >= 64) begin
                chk("done_timeout", 32'(done), 32'd1);
                break;
            end
            cyc();
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] d, input bit dr, input bit ar,
                          input logic [4:0] k, output int lat,
                          output int bc, output int sc);
        data_in = d;
        dir = dr;
        arith = ar;
        amount = k;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(lat, bc, sc);
    endtask

    int lat, bc, sc;

    initial begin
        r = 1'b0;
        start = 1'b0;
        dir = 1'b0;
        arith = 1'b0;
        amount = '0;
        data_in = '0;
        model_reset();
        cyc();
        cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_si", 32'(si), 32'd0);
        chk("rst_pi", pi, 32'd0);
        chk("rst_result", result, 32'd0);
        r = 1'b1;

        run_op(32'h0000_00F0, 0, 0, 5'd4, lat, bc, sc);
        chk("left4_result", result, 32'h0000_0F00);
        chk("left4_model", m_result, 32'h0000_0F00);
        chk("left4_busy", 32'(bc), 32'd6);
        chk("left4_lat", 32'(lat), 32'd6);
        chk("left4_shifts", 32'(sc), 32'd4);

        run_op(32'h8000_0010, 1, 1, 5'd4, lat, bc, sc);
        chk("asr4_result", result, 32'hF800_0001);
        run_op(32'h8000_0010, 1, 0, 5'd4, lat, bc, sc);
        chk("lsr4_result", result, 32'h0800_0001);
        run_op(32'h8000_0000, 1, 1, 5'd31, lat, bc, sc);
        chk("asr31_result", result, 32'hFFFF_FFFF);
        chk("asr31_lat", 32'(lat), 32'd33);

        run_op(32'hDEAD_BEEF, 1, 1, 5'd0, lat, bc, sc);
        chk("zero_result", result, 32'hDEAD_BEEF);
        chk("zero_lat", 32'(lat), 32'd2);
        chk("zero_shifts", 32'(sc), 32'd0);

        // Back-to-back: a new request in the done cycle
        run_op(32'h0000_0003, 0, 0, 5'd1, lat, bc, sc);
        chk("b2b_result", result, 32'h0000_0006);
        chk("b2b_lat", 32'(lat), 32'd3);

        // A second start while busy must be ignored
        data_in = 32'h0000_0001;
        dir = 0;
        arith = 0;
        amount = 5'd8;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        data_in = 32'hFFFF_0000;
        dir = 1;
        amount = 5'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(lat, bc, sc);
        chk("ignore_result", result, 32'h0000_0100);
        cyc();
        cyc();
        chk("ignore_no_second", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a shift
        data_in = 32'h1234_5678;
        dir = 0;
        amount = 5'd20;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        #2 r = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_result", result, 32'd0);
        model_reset();
        cyc();
        cyc();
        r = 1'b1;
        repeat (25) cyc();
        run_op(32'h0000_00A5, 0, 0, 5'd3, lat, bc, sc);
        chk("post_rst_result", result, 32'h0000_0528);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic [4:0]  k;
            int          gap;
            d = $urandom;
            k = 5'($urandom_range(0, 31));
            run_op(d, 1'($urandom), 1'($urandom), k, lat, bc, sc);
            chk("rand_lat", 32'(lat), 32'(int'(k) + 2));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
